ir_pair_sequencer: RTL and testbench



---
 rtl/ir_pair_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_ir_pair_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_pair_sequencer.sv
// Steps NUM_PAIRS IR emitter/receiver pairs through settle and right/left A2D conversions,
// publishing one weighted-difference error word per frame. Define IR_ERR_SAT_EN to saturate
// the error word (otherwise it wraps).
`timescale 1ns/1ps

module ir_pair_sequencer #(
    parameter int NUM_PAIRS     = 3,
    parameter int SETTLE_CYCLES = 4096,
    parameter int RES_W         = 12,
    parameter int ACC_W         = 16,
    parameter int ERR_W         = 12,
    parameter int CHNL_W        = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    output logic                 strt_cnv,
    output logic [CHNL_W-1:0]    chnnl,
    input  logic                 cnv_cmplt,
    input  logic [RES_W-1:0]     A2D_res,
    output logic [NUM_PAIRS-1:0] IR_en,
    output logic [ERR_W-1:0]     error,
    output logic                 err_vld,
    output logic                 err_sat,
    output logic                 busy
);

    localparam int PAIR_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int TIMER_W = $clog2(SETTLE_CYCLES);

    localparam logic [PAIR_W-1:0]    LAST_PAIR   = PAIR_W'(NUM_PAIRS - 1);
    localparam logic [TIMER_W-1:0]   SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [NUM_PAIRS-1:0] FIRST_EN    = NUM_PAIRS'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETTLE = 3'd1;
    localparam logic [2:0] WAIT_R = 3'd2;
    localparam logic [2:0] WAIT_L = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]           state, state_nxt;
    logic [PAIR_W-1:0]    pair, pair_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic [ACC_W-1:0]     acc, acc_nxt;
    logic [NUM_PAIRS-1:0] ir_en_nxt;
    logic [CHNL_W-1:0]    chnnl_nxt;
    logic                 strt_nxt;
    logic [ERR_W-1:0]     err_nxt;
    logic                 vld_nxt;
    logic                 sat_nxt;
    logic [ACC_W-1:0]     sample_term;
    logic [ERR_W-1:0]     lim_err;
    logic                 lim_sat;

    // Pair i carries weight 2^i, so each sample is scaled before it is accumulated.
    assign sample_term = {{(ACC_W - RES_W){1'b0}}, A2D_res} << pair;

`ifdef IR_ERR_SAT_EN
    localparam logic signed [ACC_W-1:0] ERR_MAX =
        {{(ACC_W - ERR_W + 1){1'b0}}, {(ERR_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ERR_MIN =
        {{(ACC_W - ERR_W + 1){1'b1}}, {(ERR_W - 1){1'b0}}};

    always_comb begin
        lim_err = acc[ERR_W-1:0];
        lim_sat = 1'b0;
        if ($signed(acc) > ERR_MAX) begin
            lim_err = ERR_MAX[ERR_W-1:0];
            lim_sat = 1'b1;
        end else if ($signed(acc) < ERR_MIN) begin
            lim_err = ERR_MIN[ERR_W-1:0];
            lim_sat = 1'b1;
        end
    end
`else
    always_comb begin
        lim_err = acc[ERR_W-1:0];
        lim_sat = 1'b0;
    end
`endif

    always_comb begin
        state_nxt = state;
        pair_nxt  = pair;
        timer_nxt = timer;
        acc_nxt   = acc;
        ir_en_nxt = IR_en;
        chnnl_nxt = chnnl;
        strt_nxt  = 1'b0;
        err_nxt   = error;
        vld_nxt   = 1'b0;
        sat_nxt   = err_sat;

        case (state)
            IDLE: begin
                if (go) begin
                    acc_nxt   = '0;
                    pair_nxt  = '0;
                    ir_en_nxt = FIRST_EN;
                    timer_nxt = '0;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (!go) begin
                    ir_en_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                    if (timer == SETTLE_LAST) begin
                        chnnl_nxt = CHNL_W'({pair, 1'b0});
                        strt_nxt  = 1'b1;
                        state_nxt = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (!go) begin
                    ir_en_nxt = '0;
                    state_nxt = IDLE;
                end else if (cnv_cmplt) begin
                    acc_nxt   = acc + sample_term;
                    chnnl_nxt = CHNL_W'({pair, 1'b1});
                    strt_nxt  = 1'b1;
                    state_nxt = WAIT_L;
                end
            end
            WAIT_L: begin
                if (!go) begin
                    ir_en_nxt = '0;
                    state_nxt = IDLE;
                end else if (cnv_cmplt) begin
                    acc_nxt = acc - sample_term;
                    if (pair == LAST_PAIR) begin
                        ir_en_nxt = '0;
                        state_nxt = DONE;
                    end else begin
                        pair_nxt  = pair + 1'b1;
                        ir_en_nxt = IR_en << 1;
                        timer_nxt = '0;
                        state_nxt = SETTLE;
                    end
                end
            end
            DONE: begin
                err_nxt = lim_err;
                vld_nxt = 1'b1;
                sat_nxt = lim_sat;
                if (go) begin
                    acc_nxt   = '0;
                    pair_nxt  = '0;
                    ir_en_nxt = FIRST_EN;
                    timer_nxt = '0;
                    state_nxt = SETTLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                ir_en_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // busy is registered from the next state so it tracks the FSM without a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pair     <= '0;
            timer    <= '0;
            acc      <= '0;
            IR_en    <= '0;
            chnnl    <= '0;
            strt_cnv <= 1'b0;
            error    <= '0;
            err_vld  <= 1'b0;
            err_sat  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pair     <= pair_nxt;
            timer    <= timer_nxt;
            acc      <= acc_nxt;
            IR_en    <= ir_en_nxt;
            chnnl    <= chnnl_nxt;
            strt_cnv <= strt_nxt;
            error    <= err_nxt;
            err_vld  <= vld_nxt;
            err_sat  <= sat_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_ir_pair_sequencer.sv
// Bench for ir_pair_sequencer: A2D responder, frame scoreboard fed by an arithmetic model,
// and a monitor checking conversion order, settle timing and error strobes.
`timescale 1ns/1ps

module tb_ir_pair_sequencer;

    localparam int NP = 3;
    localparam int SC = 8;
    localparam int RW = 12;
    localparam int AW = 16;
    localparam int EW = 12;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          cnv_cmplt;
    logic [RW-1:0] A2D_res;
    logic          strt_cnv;
    logic [CW-1:0] chnnl;
    logic [NP-1:0] IR_en;
    logic [EW-1:0] error;
    logic          err_vld;
    logic          err_sat;
    logic          busy;

    int            checks = 0;
    int            failures = 0;
    int            inject_req = 0;
    logic [RW-1:0] res_tbl [2*NP];
    logic [EW:0]   exp_q [$];
    logic [EW-1:0] last_err = '0;
    logic          last_sat = 1'b0;

    ir_pair_sequencer #(
        .NUM_PAIRS(NP), .SETTLE_CYCLES(SC), .RES_W(RW),
        .ACC_W(AW), .ERR_W(EW), .CHNL_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .IR_en(IR_en), .error(error),
        .err_vld(err_vld), .err_sat(err_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame error from the weighting rule: sum of (right-left)*2^i, then limited to ERR_W bits.
    function automatic logic [EW:0] model_frame();
        int acc = 0;
        int vmax = (1 << (EW - 1)) - 1;
        int vmin = -(1 << (EW - 1));
        for (int i = 0; i < NP; i++)
            acc += (int'(res_tbl[2*i]) - int'(res_tbl[2*i+1])) * (1 << i);
`ifdef IR_ERR_SAT_EN
        if (acc > vmax) return {1'b1, vmax[EW-1:0]};
        if (acc < vmin) return {1'b1, vmin[EW-1:0]};
`else
        if (vmax < vmin) return '0;
`endif
        return {1'b0, acc[EW-1:0]};
    endfunction

    task automatic set_tables(input bit rnd, input logic [RW-1:0] r, input logic [RW-1:0] l);
        for (int i = 0; i < NP; i++) begin
            res_tbl[2*i]   = rnd ? RW'($urandom) : r;
            res_tbl[2*i+1] = rnd ? RW'($urandom) : l;
        end
    endtask

    task automatic apply_stimulus(input bit rnd, input logic [RW-1:0] r, input logic [RW-1:0] l);
        logic [EW:0] e;
        set_tables(rnd, r, l);
        e = model_frame();
        exp_q.push_back(e);
        last_err = e[EW-1:0];
        last_sat = e[EW];
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (err_vld) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL err_vld_timeout: got no strobe expected one within 3000 cycles");
        end
    endtask

    // One frame with go held; the last frame drops go while the DUT is already resettling.
    task automatic run_frame(input bit rnd, input logic [RW-1:0] r, input logic [RW-1:0] l,
                             input bit inject, input bit last);
        bit ok;
        apply_stimulus(rnd, r, l);
        go = 1'b1;
        if (inject) begin
            repeat (3) @(negedge clk);
            inject_req++;
        end
        wait_vld(ok);
        if (ok && !last) begin
            check_output("restart_ir_en", 32'(IR_en), 32'(1));
            check_output("restart_busy", 32'(busy), 32'(1));
        end
        if (last) begin
            go = 1'b0;
            repeat (4) @(negedge clk);
            check_output("idle_busy", 32'(busy), 32'(0));
        end
    endtask

    // A2D responder: answers each strt_cnv after 1-4 cycles, or injects a stray cnv_cmplt on request.
    initial begin
        int pend_cnt;
        int pend_ch;
        int inj_done;
        pend_cnt = 0;
        pend_ch = 0;
        inj_done = 0;
        cnv_cmplt = 1'b0;
        A2D_res = '0;
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    cnv_cmplt = 1'b1;
                    A2D_res = res_tbl[pend_ch];
                end
            end else if (inj_done != inject_req) begin
                inj_done++;
                cnv_cmplt = 1'b1;
                A2D_res = 12'hABC;
            end
            if (strt_cnv) begin
                pend_ch = int'(chnnl);
                pend_cnt = $urandom_range(1, 4);
            end
        end
    end

    initial begin
        int seq;
        int settle_cnt;
        logic [NP-1:0] prev_ir;
        logic prev_vld;
        logic prev_strt;
        logic [EW:0] e;
        seq = 0;
        settle_cnt = 0;
        prev_ir = '0;
        prev_vld = 1'b0;
        prev_strt = 1'b0;
        forever begin
            @(negedge clk);
            if (IR_en != prev_ir) settle_cnt = 0;
            else settle_cnt++;
            if (strt_cnv) begin
                check_output("strt_chnnl", 32'(chnnl), 32'(seq));
                check_output("strt_ir_en", 32'(IR_en), 32'(1 << (seq / 2)));
                if (seq % 2 == 0) check_output("settle_time", 32'(settle_cnt), 32'(SC));
                seq = (seq + 1) % (2 * NP);
            end
            if (prev_strt) check_output("strt_pulse", 32'(strt_cnv), 32'(0));
            if (err_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_err_vld: got strobe with error 0x%0h expected none", error);
                end else begin
                    e = exp_q.pop_front();
                    check_output("error", 32'(error), 32'(e[EW-1:0]));
                    check_output("err_sat", 32'(err_sat), 32'(e[EW]));
                end
            end
            if (prev_vld) check_output("vld_pulse", 32'(err_vld), 32'(0));
            if (!busy) seq = 0;
            prev_ir = IR_en;
            prev_vld = err_vld;
            prev_strt = strt_cnv;
        end
    end

    initial begin
        int strt_seen;
        int busy_seen;
        int vld_seen;
        bit found;
        set_tables(1'b0, '0, '0);

        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'(0));
        check_output("rst_ir_en", 32'(IR_en), 32'(0));
        check_output("rst_strt", 32'(strt_cnv), 32'(0));
        check_output("rst_chnnl", 32'(chnnl), 32'(0));
        check_output("rst_error", 32'(error), 32'(0));
        check_output("rst_err_vld", 32'(err_vld), 32'(0));
        check_output("rst_err_sat", 32'(err_sat), 32'(0));

        rst_n = 1'b1;
        go = 1'b1;
        repeat (4) @(negedge clk);
        check_output("settle_ir_en", 32'(IR_en), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_output("async_ir_en", 32'(IR_en), 32'(0));
        check_output("async_busy", 32'(busy), 32'(0));
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        strt_seen = 0;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (strt_cnv) strt_seen++;
            if (busy) busy_seen++;
        end
        check_output("post_rst_strt", 32'(strt_seen), 32'(0));
        check_output("post_rst_busy", 32'(busy_seen), 32'(0));

        run_frame(1'b0, 12'h100, 12'h000, 1'b1, 1'b0);
        run_frame(1'b0, 12'h000, 12'h080, 1'b0, 1'b1);
        run_frame(1'b0, 12'hFFF, 12'h000, 1'b0, 1'b0);
        run_frame(1'b0, 12'h000, 12'hFFF, 1'b0, 1'b1);
        for (int f = 0; f < 6; f++)
            run_frame(1'b1, '0, '0, 1'b0, (f == 5));

        set_tables(1'b1, '0, '0);
        go = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (strt_cnv && chnnl == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        check_output("abort_reached", 32'(found), 32'(1));
        go = 1'b0;
        @(negedge clk);
        check_output("abort_ir_en", 32'(IR_en), 32'(0));
        check_output("abort_busy", 32'(busy), 32'(0));
        check_output("abort_strt", 32'(strt_cnv), 32'(0));
        check_output("abort_error", 32'(error), 32'(last_err));
        check_output("abort_err_sat", 32'(err_sat), 32'(last_sat));
        vld_seen = 0;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (err_vld) vld_seen++;
            if (busy) busy_seen++;
        end
        check_output("abort_no_vld", 32'(vld_seen), 32'(0));
        check_output("abort_stays_idle", 32'(busy_seen), 32'(0));
        check_output("abort_error_held", 32'(error), 32'(last_err));
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
